// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: stalls the core, writes back a dirty victim, fetches and fills the
// line, then replays once. Define DCACHE_MISS_PERF_EN to add miss/write-back performance counters.
module dcache_miss_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned WAY_W  = 2,
  parameter int unsigned LINE_W = 128
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    kill_i,
  input  logic [ADDR_W-1:0]       c_addr_i,
  input  logic                    c_hit_i,
  input  logic                    c_miss_i,
  input  logic [WAY_W-1:0]        c_lru_way_i,
  input  logic                    victim_dirty_i,
  input  logic [ADDR_W-OFF_W-1:0] victim_line_addr_i,
  input  logic [LINE_W-1:0]       victim_data_i,
  output logic                    stall_core_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-OFF_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0]       mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [LINE_W-1:0]       mem_rdata_i,
`ifdef DCACHE_MISS_PERF_EN
  output logic [31:0]             perf_miss_cnt_o,
  output logic [31:0]             perf_wb_cnt_o,
`endif
  output logic                    fill_we_o,
  output logic [WAY_W-1:0]        fill_way_o,
  output logic [ADDR_W-OFF_W-1:0] fill_line_addr_o,
  output logic [LINE_W-1:0]       fill_data_o
);

  typedef enum logic [2:0] {StIdle, StWb, StFill, StWrite, StReplay} state_e;

  state_e                    state_q;
  logic                      stall_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [ADDR_W-OFF_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]         mem_wdata_q;
  logic                      fill_we_q;
  logic [WAY_W-1:0]          way_q;
  logic [ADDR_W-OFF_W-1:0]   miss_line_q;
  logic [LINE_W-1:0]         fill_buf_q;

  logic miss_start;
  logic wb_done;
  logic unused_bits;

  assign miss_start  = (state_q == StIdle) && c_miss_i && !kill_i;
  assign wb_done     = (state_q == StWb) && mem_ack_i;
  // A hit flagged together with a miss is treated as a miss, so c_hit_i plays no role.
  assign unused_bits = ^{c_hit_i, c_addr_i[OFF_W-1:0]};

  // In IDLE the stall must reach the stage latch in the same cycle the miss appears.
  assign stall_core_o     = (state_q == StIdle) ? (c_miss_i & ~kill_i) : stall_q;
  assign mem_req_o        = mem_req_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign fill_we_o        = fill_we_q;
  assign fill_way_o       = way_q;
  assign fill_line_addr_o = miss_line_q;
  assign fill_data_o      = fill_buf_q;

  // Victim address/data are latched directly into the memory request registers.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q     <= StIdle;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_we_q   <= 1'b0;
      way_q       <= '0;
      miss_line_q <= '0;
      fill_buf_q  <= '0;
    end else begin
      fill_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_start) begin
            miss_line_q <= c_addr_i[ADDR_W-1:OFF_W];
            way_q       <= c_lru_way_i;
            stall_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            if (victim_dirty_i) begin
              state_q     <= StWb;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= victim_line_addr_i;
              mem_wdata_q <= victim_data_i;
            end else begin
              state_q     <= StFill;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= c_addr_i[ADDR_W-1:OFF_W];
              mem_wdata_q <= '0;
            end
          end
        end
        StWb: begin
          if (mem_ack_i) begin
            state_q     <= StFill;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= miss_line_q;
            mem_wdata_q <= '0;
          end
        end
        StFill: begin
          if (mem_ack_i) begin
            state_q    <= StWrite;
            fill_buf_q <= mem_rdata_i;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fill_we_q  <= 1'b1;
          end
        end
        StWrite: begin
          state_q <= StReplay;
          stall_q <= 1'b0;
        end
        StReplay: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DCACHE_MISS_PERF_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_done)    wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign perf_miss_cnt_o = miss_cnt_q;
  assign perf_wb_cnt_o   = wb_cnt_q;
`else
  logic unused_wb_done;
  assign unused_wb_done = wb_done;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: reset, clean/dirty misses, kill, spurious ack, back-to-back.
module tb_dcache_miss_ctrl;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         kill_i;
  logic [19:0]  c_addr_i;
  logic         c_hit_i;
  logic         c_miss_i;
  logic [1:0]   c_lru_way_i;
  logic         victim_dirty_i;
  logic [15:0]  victim_line_addr_i;
  logic [127:0] victim_data_i;
  logic         stall_core_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [15:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [127:0] mem_rdata_i;
  logic         fill_we_o;
  logic [1:0]   fill_way_o;
  logic [15:0]  fill_line_addr_o;
  logic [127:0] fill_data_o;
`ifdef DCACHE_MISS_PERF_EN
  logic [31:0]  perf_miss_cnt_o;
  logic [31:0]  perf_wb_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int exp_miss = 0;
  int exp_wb = 0;

  localparam logic [127:0] PatA = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [127:0] PatB = 128'hBEEF_1111_BEEF_2222_BEEF_3333_BEEF_4444;
  localparam logic [127:0] PatC = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk_i = ~clk_i;

  dcache_miss_ctrl dut (
    .clk_i              (clk_i),
    .rsn_i              (rsn_i),
    .kill_i             (kill_i),
    .c_addr_i           (c_addr_i),
    .c_hit_i            (c_hit_i),
    .c_miss_i           (c_miss_i),
    .c_lru_way_i        (c_lru_way_i),
    .victim_dirty_i     (victim_dirty_i),
    .victim_line_addr_i (victim_line_addr_i),
    .victim_data_i      (victim_data_i),
    .stall_core_o       (stall_core_o),
    .mem_req_o          (mem_req_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_ack_i          (mem_ack_i),
    .mem_rdata_i        (mem_rdata_i),
`ifdef DCACHE_MISS_PERF_EN
    .perf_miss_cnt_o    (perf_miss_cnt_o),
    .perf_wb_cnt_o      (perf_wb_cnt_o),
`endif
    .fill_we_o          (fill_we_o),
    .fill_way_o         (fill_way_o),
    .fill_line_addr_o   (fill_line_addr_o),
    .fill_data_o        (fill_data_o)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    kill_i = 0; c_miss_i = 0; c_hit_i = 0; mem_ack_i = 0; victim_dirty_i = 0;
  endtask

  task automatic test_reset();
    rsn_i = 0; idle_inputs();
    c_addr_i = '0; c_lru_way_i = '0; victim_line_addr_i = '0; victim_data_i = '0;
    mem_rdata_i = '0;
    tick(); tick();
    rsn_i = 1;
    // Start a clean miss to get into FILL, then reset mid-request.
    c_addr_i = 20'h0_7770; c_miss_i = 1; tick(); c_miss_i = 0;
    checks++; if (mem_req_o !== 1'b1) begin errors++;
      $display("FAIL reset_pre_req: got %b want 1", mem_req_o); end
    rsn_i = 0; tick(); tick(); rsn_i = 1; #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++; if (fill_we_o !== 1'b0) begin errors++;
      $display("FAIL reset_fill_we: got %b want 0", fill_we_o); end
    checks++; if (stall_core_o !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b want 0", stall_core_o); end
    checks++; if (mem_addr_o !== 16'h0) begin errors++;
      $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    // Ack after reset must not complete anything.
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (fill_we_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++;
      $display("FAIL reset_no_completion: fill_we=%b req=%b want 0 0", fill_we_o, mem_req_o); end
  endtask

  task automatic test_clean_miss();
    c_addr_i = 20'h0_1230; c_lru_way_i = 2; victim_dirty_i = 0; c_miss_i = 1; c_hit_i = 1; #1;
    checks++; if (stall_core_o !== 1'b1) begin errors++;
      $display("FAIL clean_comb_stall: got %b want 1", stall_core_o); end
    tick(); c_miss_i = 0; c_hit_i = 0; exp_miss++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 16'h0123 ||
          stall_core_o !== 1'b1 || fill_we_o !== 1'b0) begin
        errors++;
        $display("FAIL clean_fill_req[%0d]: req=%b we=%b addr=%h stall=%b fwe=%b want 1 0 0123 1 0",
                 i, mem_req_o, mem_we_o, mem_addr_o, stall_core_o, fill_we_o);
      end
      if (i == 2) begin mem_ack_i = 1; mem_rdata_i = PatA; end
      tick();
    end
    mem_ack_i = 0; mem_rdata_i = '0;
    checks++;
    if (fill_we_o !== 1'b1 || fill_way_o !== 2'd2 || fill_line_addr_o !== 16'h0123 ||
        fill_data_o !== PatA || mem_req_o !== 1'b0 || stall_core_o !== 1'b1) begin
      errors++;
      $display("FAIL clean_write: fwe=%b way=%0d line=%h data=%h req=%b stall=%b",
               fill_we_o, fill_way_o, fill_line_addr_o, fill_data_o, mem_req_o, stall_core_o);
    end
    checks++; if (mem_addr_o !== 16'h0 || mem_we_o !== 1'b0) begin errors++;
      $display("FAIL clean_idle_bus: addr=%h we=%b want 0 0", mem_addr_o, mem_we_o); end
    tick();
    checks++; if (fill_we_o !== 1'b0 || stall_core_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL clean_replay: fwe=%b stall=%b req=%b want 0 0 0",
               fill_we_o, stall_core_o, mem_req_o);
    end
    tick();
  endtask

  task automatic test_dirty_miss();
    c_addr_i = 20'h0_ABC0; c_lru_way_i = 1; victim_dirty_i = 1;
    victim_line_addr_i = 16'h0456; victim_data_i = PatB; c_miss_i = 1;
    tick(); c_miss_i = 0; exp_miss++;
    victim_line_addr_i = 16'hFFFF; victim_data_i = PatC; victim_dirty_i = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 16'h0456 ||
          mem_wdata_o !== PatB || stall_core_o !== 1'b1) begin
        errors++;
        $display("FAIL dirty_wb[%0d]: req=%b we=%b addr=%h wdata=%h stall=%b",
                 i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_core_o);
      end
      if (i == 1) mem_ack_i = 1;
      tick();
    end
    exp_wb++; mem_ack_i = 0;
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 16'h0ABC ||
        mem_wdata_o !== 128'h0 || stall_core_o !== 1'b1) begin
      errors++;
      $display("FAIL dirty_fill: req=%b we=%b addr=%h wdata=%h stall=%b",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_core_o);
    end
    mem_ack_i = 1; mem_rdata_i = PatC; tick(); mem_ack_i = 0;
    checks++;
    if (fill_we_o !== 1'b1 || fill_way_o !== 2'd1 || fill_line_addr_o !== 16'h0ABC ||
        fill_data_o !== PatC || stall_core_o !== 1'b1) begin
      errors++;
      $display("FAIL dirty_write: fwe=%b way=%0d line=%h data=%h stall=%b",
               fill_we_o, fill_way_o, fill_line_addr_o, fill_data_o, stall_core_o);
    end
    tick();
    checks++; if (stall_core_o !== 1'b0 || fill_we_o !== 1'b0) begin errors++;
      $display("FAIL dirty_replay: stall=%b fwe=%b want 0 0", stall_core_o, fill_we_o); end
    tick();
  endtask

  task automatic test_kill();
    c_addr_i = 20'h0_5550; c_miss_i = 1; kill_i = 1; victim_dirty_i = 1; #1;
    checks++; if (stall_core_o !== 1'b0) begin errors++;
      $display("FAIL kill_idle_stall: got %b want 0", stall_core_o); end
    tick();
    checks++; if (mem_req_o !== 1'b0 || stall_core_o !== 1'b0) begin errors++;
      $display("FAIL kill_idle_req: req=%b stall=%b want 0 0", mem_req_o, stall_core_o); end
    kill_i = 0; victim_dirty_i = 0; c_lru_way_i = 3;
    tick(); c_miss_i = 0; exp_miss++;
    kill_i = 1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0555) begin errors++;
      $display("FAIL kill_fill_req: req=%b addr=%h want 1 0555", mem_req_o, mem_addr_o); end
    mem_ack_i = 1; mem_rdata_i = PatA; tick(); mem_ack_i = 0;
    checks++;
    if (fill_we_o !== 1'b1 || fill_way_o !== 2'd3 || fill_data_o !== PatA) begin errors++;
      $display("FAIL kill_fill_done: fwe=%b way=%0d data=%h", fill_we_o, fill_way_o, fill_data_o);
    end
    kill_i = 0;
    tick(); tick();
  endtask

  task automatic test_spurious_ack();
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (mem_req_o !== 1'b0 || fill_we_o !== 1'b0 || stall_core_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: req=%b fwe=%b stall=%b want 0 0 0",
               mem_req_o, fill_we_o, stall_core_o);
    end
    c_addr_i = 20'h0_2220; c_lru_way_i = 0; c_miss_i = 1; tick(); c_miss_i = 0; exp_miss++;
    mem_ack_i = 1; mem_rdata_i = PatB; tick();   // FILL -> WRITE
    tick();                                      // WRITE -> REPLAY, ack still high
    checks++; if (fill_we_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++;
      $display("FAIL ack_replay: fwe=%b req=%b want 0 0", fill_we_o, mem_req_o); end
    tick();                                      // REPLAY -> IDLE
    checks++; if (fill_we_o !== 1'b0 || mem_req_o !== 1'b0 || stall_core_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_after_replay: fwe=%b req=%b stall=%b want 0 0 0",
               fill_we_o, mem_req_o, stall_core_o);
    end
    mem_ack_i = 0;
  endtask

  task automatic test_back_to_back();
    c_addr_i = 20'h0_3330; c_lru_way_i = 1; c_miss_i = 1; victim_dirty_i = 0;
    tick(); c_miss_i = 0; exp_miss++;
    mem_ack_i = 1; mem_rdata_i = PatC; tick(); mem_ack_i = 0;
    tick();                                      // now in REPLAY
    c_addr_i = 20'h0_4440; c_miss_i = 1; victim_dirty_i = 1;
    victim_line_addr_i = 16'h0999; victim_data_i = PatA; #1;
    checks++; if (stall_core_o !== 1'b0) begin errors++;
      $display("FAIL b2b_replay_stall: got %b want 0", stall_core_o); end
    tick();                                      // IDLE with miss present
    checks++; if (stall_core_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++;
      $display("FAIL b2b_idle_stall: stall=%b req=%b want 1 0", stall_core_o, mem_req_o); end
    tick(); c_miss_i = 0; exp_miss++;
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 16'h0999) begin errors++;
      $display("FAIL b2b_wb: req=%b we=%b addr=%h want 1 1 0999", mem_req_o, mem_we_o, mem_addr_o);
    end
    mem_ack_i = 1; tick(); tick(); mem_ack_i = 0; exp_wb++;
    checks++; if (fill_we_o !== 1'b1 || fill_line_addr_o !== 16'h0444) begin errors++;
      $display("FAIL b2b_write: fwe=%b line=%h want 1 0444", fill_we_o, fill_line_addr_o); end
    tick(); tick();
`ifdef DCACHE_MISS_PERF_EN
    checks++; if (perf_miss_cnt_o !== 32'(exp_miss)) begin errors++;
      $display("FAIL perf_miss: got %0d want %0d", perf_miss_cnt_o, exp_miss); end
    checks++; if (perf_wb_cnt_o !== 32'(exp_wb)) begin errors++;
      $display("FAIL perf_wb: got %0d want %0d", perf_wb_cnt_o, exp_wb); end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_kill();
    test_spurious_ack();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
